// File: rtl/dpsram_fifo_ctrl.sv
// Synchronous FIFO controller using a dual-port SRAM (port A write, port B read) with a
// 2-entry show-ahead output buffer. Optional occupancy/threshold outputs: DPSRAM_FIFO_LEVEL_EN.
module dpsram_fifo_ctrl #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 20,
  parameter int AFULL_TH = 56
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WR_VALID,
  output logic              WR_READY,
  input  logic [DATA_W-1:0] WR_DATA,
  output logic              RD_VALID,
  input  logic              RD_READY,
  output logic [DATA_W-1:0] RD_DATA,
  output logic [ADDR_W-1:0] A_ADDR,
  output logic              A_BLK_EN,
  output logic              A_WEN,
  output logic [DATA_W-1:0] A_DIN,
  output logic [ADDR_W-1:0] B_ADDR,
  output logic              B_BLK_EN,
  output logic              B_WEN,
  output logic [DATA_W-1:0] B_DIN,
  input  logic [DATA_W-1:0] B_DOUT,
  output logic [ADDR_W+1:0] LEVEL,
  output logic              ALMOST_FULL
);

  logic [ADDR_W-1:0] wptr, rptr;
  logic [ADDR_W:0]   sram_cnt;
  logic              inflight;
  logic              run;
  logic [1:0]        buf_cnt;
  logic [DATA_W-1:0] buf0, buf1;
  logic              push, pop, rd_issue;
  logic [2:0]        occ_after_pop;

  // run holds WR_READY low until the first edge after reset release
  assign WR_READY = run & ~sram_cnt[ADDR_W];
  assign push     = WR_VALID & WR_READY;
  assign pop      = RD_READY & (buf_cnt != 2'd0);

  // Words that will occupy the buffer once this cycle's pop and pending capture settle
  assign occ_after_pop = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign rd_issue      = (sram_cnt != '0) & (occ_after_pop < 3'd2);

  assign A_ADDR   = wptr;
  assign A_BLK_EN = push;
  assign A_WEN    = push;
  assign A_DIN    = WR_DATA;
  assign B_ADDR   = rptr;
  assign B_BLK_EN = rd_issue;
  assign B_WEN    = 1'b0;
  assign B_DIN    = '0;
  assign RD_VALID = (buf_cnt != 2'd0);
  assign RD_DATA  = buf0;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      run      <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      sram_cnt <= '0;
      inflight <= 1'b0;
      buf_cnt  <= 2'd0;
      buf0     <= '0;
      buf1     <= '0;
    end else begin
      run      <= 1'b1;
      inflight <= rd_issue;
      if (push)     wptr <= wptr + 1'b1;
      if (rd_issue) rptr <= rptr + 1'b1;
      case ({push, rd_issue})
        2'b10:   sram_cnt <= sram_cnt + 1'b1;
        2'b01:   sram_cnt <= sram_cnt - 1'b1;
        default: sram_cnt <= sram_cnt;
      endcase
      if (pop && buf_cnt == 2'd2) buf0 <= buf1;
      // Captured word lands in the first slot left free after this cycle's pop
      if (inflight) begin
        if (buf_cnt == {1'b0, pop}) buf0 <= B_DOUT;
        else                        buf1 <= B_DOUT;
      end
      buf_cnt <= buf_cnt + {1'b0, inflight} - {1'b0, pop};
    end
  end

`ifdef DPSRAM_FIFO_LEVEL_EN
  localparam logic [ADDR_W+1:0] AFULL_LVL = (ADDR_W+2)'(AFULL_TH);

  logic [ADDR_W+1:0] level_q, level_nxt;
  logic              afull_q;

  // sram_cnt + inflight + buf_cnt only moves on push and pop; reads and captures cancel out
  always_comb begin
    level_nxt = level_q + {{(ADDR_W+1){1'b0}}, push} - {{(ADDR_W+1){1'b0}}, pop};
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      level_q <= '0;
      afull_q <= 1'b0;
    end else begin
      level_q <= level_nxt;
      afull_q <= (level_nxt >= AFULL_LVL);
    end
  end

  assign LEVEL       = level_q;
  assign ALMOST_FULL = afull_q;
`else
  // threshold only matters when occupancy tracking is built in
  logic unused_afull_th;
  assign unused_afull_th = ^AFULL_TH;
  assign LEVEL           = '0;
  assign ALMOST_FULL     = 1'b0;
`endif

endmodule
